// File: rtl/gcm_pkg.sv
// Shared types and constants for the AES-GCM front end.
// Block-count helper turns a bit length into a ceil(bits/128) block count.
package gcm_pkg;

   localparam int unsigned GCM_BLK_W = 128;
   localparam int unsigned GCM_IV_W  = 96;
   localparam int unsigned GCM_LEN_W = 64;

   typedef enum logic [1:0] {
      StIdle,
      StAad,
      StPt,
      StLen
   } gcm_seq_state_t;

   function automatic logic [63:0] blk_count(input logic [0:GCM_LEN_W-1] bits);
      return {7'd0, bits[0:56]} + 64'(|bits[57:63]);
   endfunction

endpackage

// File: rtl/gcm_blk_mask.sv
// Zero-pads a 128-bit block, MSB-first: keeps bits [0:r-1] and clears [r:127].
// A residue of 0 means a full block and passes it through unchanged.
module gcm_blk_mask
   import gcm_pkg::*;
(
   input  logic [0:GCM_BLK_W-1] blk_i,
   input  logic [6:0]           res_i,
   output logic [0:GCM_BLK_W-1] blk_o
);

   always_comb begin
      blk_o = blk_i;
      if (res_i != 7'd0) begin
         for (int i = 0; i < int'(GCM_BLK_W); i++) begin
            if (i >= int'(res_i)) blk_o[i] = 1'b0;
         end
      end
   end

endmodule

// File: rtl/gcm_instance_sequencer.sv
// Front-end sequencer: frames one GCM instance (AAD beats, PT beats, length beat)
// into the non-stalling pipeline, padding partial blocks and inserting bubbles.
module gcm_instance_sequencer
   import gcm_pkg::*;
#(
   parameter int unsigned BLK_CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_desc_valid,
   output logic                 o_desc_ready,
   input  logic [0:GCM_IV_W-1]  i_desc_iv,
   input  logic [0:GCM_LEN_W-1] i_desc_aad_bits,
   input  logic [0:GCM_LEN_W-1] i_desc_pt_bits,
   input  logic                 i_blk_valid,
   output logic                 o_blk_ready,
   input  logic [0:GCM_BLK_W-1] i_blk_data,
   output logic                 o_pipe_valid,
   output logic [0:GCM_BLK_W-1] o_aad,
   output logic [0:GCM_BLK_W-1] o_plain_text,
   output logic [0:GCM_IV_W-1]  o_iv,
   output logic [0:GCM_BLK_W-1] o_instance_size,
   output logic                 o_new_instance,
   output logic                 o_pt_instance,
   output logic                 o_last,
   output logic                 o_err
);

   gcm_seq_state_t       state_q;
   logic                 first_q;
   logic                 pt_first_q;
   logic [BLK_CNT_W-1:0] aad_cnt_q;
   logic [BLK_CNT_W-1:0] pt_cnt_q;

   logic [63:0]          aad_blks;
   logic [63:0]          pt_blks;
   logic                 oversize;
   logic                 sec_last;
   logic [6:0]           mask_res;
   logic [0:GCM_BLK_W-1] blk_masked;

   assign o_desc_ready = (state_q == StIdle);
   assign o_blk_ready  = (state_q == StAad) || (state_q == StPt);

   assign aad_blks = blk_count(i_desc_aad_bits);
   assign pt_blks  = blk_count(i_desc_pt_bits);
   assign oversize = (|(aad_blks >> BLK_CNT_W)) || (|(pt_blks >> BLK_CNT_W));

   // Residues come from the latched instance size, so no extra registers are needed.
   always_comb begin
      sec_last = (state_q == StAad) ? (aad_cnt_q == BLK_CNT_W'(1))
                                    : (pt_cnt_q == BLK_CNT_W'(1));
      mask_res = 7'd0;
      if (sec_last) begin
         mask_res = (state_q == StAad) ? o_instance_size[57:63] : o_instance_size[121:127];
      end
   end

   gcm_blk_mask u_mask (
      .blk_i (i_blk_data),
      .res_i (mask_res),
      .blk_o (blk_masked)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         first_q         <= 1'b0;
         pt_first_q      <= 1'b0;
         aad_cnt_q       <= '0;
         pt_cnt_q        <= '0;
         o_pipe_valid    <= 1'b0;
         o_aad           <= '0;
         o_plain_text    <= '0;
         o_iv            <= '0;
         o_instance_size <= '0;
         o_new_instance  <= 1'b0;
         o_pt_instance   <= 1'b0;
         o_last          <= 1'b0;
         o_err           <= 1'b0;
      end else begin
         // Default to a bubble; each state overrides when it emits a beat.
         o_pipe_valid   <= 1'b0;
         o_aad          <= '0;
         o_plain_text   <= '0;
         o_new_instance <= 1'b0;
         o_pt_instance  <= 1'b0;
         o_last         <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (i_desc_valid) begin
                  o_iv            <= i_desc_iv;
                  o_instance_size <= {i_desc_aad_bits, i_desc_pt_bits};
                  if (oversize) begin
                     o_err <= 1'b1;
                  end else begin
                     aad_cnt_q  <= aad_blks[BLK_CNT_W-1:0];
                     pt_cnt_q   <= pt_blks[BLK_CNT_W-1:0];
                     first_q    <= 1'b1;
                     pt_first_q <= 1'b1;
                     if (aad_blks != 64'd0)     state_q <= StAad;
                     else if (pt_blks != 64'd0) state_q <= StPt;
                     else                       state_q <= StLen;
                  end
               end
            end
            StAad: begin
               if (i_blk_valid) begin
                  o_pipe_valid   <= 1'b1;
                  o_aad          <= blk_masked;
                  o_new_instance <= first_q;
                  first_q        <= 1'b0;
                  aad_cnt_q      <= aad_cnt_q - BLK_CNT_W'(1);
                  if (sec_last) state_q <= (pt_cnt_q != '0) ? StPt : StLen;
               end
            end
            StPt: begin
               if (i_blk_valid) begin
                  o_pipe_valid   <= 1'b1;
                  o_plain_text   <= blk_masked;
                  o_new_instance <= first_q;
                  o_pt_instance  <= pt_first_q;
                  first_q        <= 1'b0;
                  pt_first_q     <= 1'b0;
                  pt_cnt_q       <= pt_cnt_q - BLK_CNT_W'(1);
                  if (sec_last) state_q <= StLen;
               end
            end
            StLen: begin
               o_pipe_valid   <= 1'b1;
               o_last         <= 1'b1;
               o_new_instance <= first_q;
               first_q        <= 1'b0;
               state_q        <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gcm_instance_sequencer.sv
// Directed, table-driven bench for gcm_instance_sequencer with hand-computed beats,
// plus hand sequences for oversize descriptors and mid-instance reset.
module tb_gcm_instance_sequencer;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_desc_valid;
   logic         o_desc_ready;
   logic [0:95]  i_desc_iv;
   logic [0:63]  i_desc_aad_bits;
   logic [0:63]  i_desc_pt_bits;
   logic         i_blk_valid;
   logic         o_blk_ready;
   logic [0:127] i_blk_data;
   logic         o_pipe_valid;
   logic [0:127] o_aad;
   logic [0:127] o_plain_text;
   logic [0:95]  o_iv;
   logic [0:127] o_instance_size;
   logic         o_new_instance;
   logic         o_pt_instance;
   logic         o_last;
   logic         o_err;

   gcm_instance_sequencer #(.BLK_CNT_W(32)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_desc_valid    (i_desc_valid),
      .o_desc_ready    (o_desc_ready),
      .i_desc_iv       (i_desc_iv),
      .i_desc_aad_bits (i_desc_aad_bits),
      .i_desc_pt_bits  (i_desc_pt_bits),
      .i_blk_valid     (i_blk_valid),
      .o_blk_ready     (o_blk_ready),
      .i_blk_data      (i_blk_data),
      .o_pipe_valid    (o_pipe_valid),
      .o_aad           (o_aad),
      .o_plain_text    (o_plain_text),
      .o_iv            (o_iv),
      .o_instance_size (o_instance_size),
      .o_new_instance  (o_new_instance),
      .o_pt_instance   (o_pt_instance),
      .o_last          (o_last),
      .o_err           (o_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0]  aad_bits;
      logic [63:0]  pt_bits;
      logic [95:0]  iv;
      logic [127:0] base;
      logic [7:0]   vpat;
      int           n_aad;
      int           n_pt;
      logic [127:0] aad_last;
      logic [127:0] pt_last;
      logic [127:0] size;
   } vec_t;

   localparam logic [127:0] Base = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] Ones = {128{1'b1}};

   vec_t vecs[5];
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] blk(input logic [127:0] base, input int k);
      return base ^ 128'(k);
   endfunction

   task automatic run_vec(input int v);
      vec_t         t;
      int           k;
      int           beat;
      int           dp;
      logic         hs_pend;
      logic         done;
      logic [2:0]   ef;
      logic [127:0] ea;
      logic [127:0] ep;
      t       = vecs[v];
      k       = 0;
      beat    = 0;
      hs_pend = 1'b0;
      done    = 1'b0;
      i_desc_valid    = 1'b1;
      i_desc_iv       = t.iv;
      i_desc_aad_bits = t.aad_bits;
      i_desc_pt_bits  = t.pt_bits;
      i_blk_valid     = 1'b0;
      for (int cyc = 0; cyc < 40 && !done; cyc++) begin
         @(posedge clk);
         #1;
         if (hs_pend) k++;
         i_desc_valid = 1'b0;
         if (o_pipe_valid) begin
            ef = {beat == 0, (t.n_pt > 0) && (beat == t.n_aad), beat == t.n_aad + t.n_pt};
            ea = '0;
            if (beat < t.n_aad) ea = (beat == t.n_aad - 1) ? t.aad_last : blk(t.base, beat);
            ep = '0;
            dp = beat - t.n_aad;
            if (dp >= 0 && dp < t.n_pt) ep = (dp == t.n_pt - 1) ? t.pt_last : blk(t.base, beat);
            check($sformatf("v%0d beat%0d flags(new,pt,last)", v, beat),
                  128'({o_new_instance, o_pt_instance, o_last}), 128'(ef));
            check($sformatf("v%0d beat%0d aad", v, beat), o_aad, ea);
            check($sformatf("v%0d beat%0d plain_text", v, beat), o_plain_text, ep);
            if (o_last) done = 1'b1;
            beat++;
         end else begin
            check($sformatf("v%0d cyc%0d bubble clean", v, cyc),
                  128'({o_new_instance, o_pt_instance, o_last, |o_aad, |o_plain_text}), 128'd0);
         end
         hs_pend = 1'b0;
         if (!done && k < t.n_aad + t.n_pt && t.vpat[cyc % 8]) begin
            i_blk_valid = 1'b1;
            i_blk_data  = blk(t.base, k);
            hs_pend     = o_blk_ready;
         end else begin
            i_blk_valid = 1'b0;
         end
      end
      i_blk_valid = 1'b0;
      check($sformatf("v%0d reached last beat", v), 128'(done), 128'd1);
      check($sformatf("v%0d beat count", v), 128'(beat), 128'(t.n_aad + t.n_pt + 1));
      check($sformatf("v%0d instance_size", v), o_instance_size, t.size);
      check($sformatf("v%0d iv", v), 128'(o_iv), 128'(t.iv));
   endtask

   initial begin
      int pt_beats;
      vecs[0] = '{64'd256, 64'd384, 96'hCAFEBABE_DEADBEEF_01234567, Base, 8'hFF, 2, 3,
                  128'h00112233445566778899AABBCCDDEEFE, 128'h00112233445566778899AABBCCDDEEFB,
                  128'h0000000000000100_0000000000000180};
      vecs[1] = '{64'd0, 64'd100, 96'h111111112222222233333333, Ones, 8'hFF, 0, 1,
                  128'd0, 128'hFFFFFFFFFFFFFFFFFFFFFFFFF0000000,
                  128'h0000000000000000_0000000000000064};
      vecs[2] = '{64'd0, 64'd0, 96'hABCDEF000000000000000001, Base, 8'hFF, 0, 0,
                  128'd0, 128'd0, 128'd0};
      vecs[3] = '{64'd128, 64'd256, 96'h0F0F0F0F0F0F0F0F0F0F0F0F, Base, 8'hF9, 1, 2,
                  Base, 128'h00112233445566778899AABBCCDDEEFD,
                  128'h0000000000000080_0000000000000100};
      vecs[4] = '{64'd200, 64'd136, 96'h123456789ABCDEF012345678, Ones, 8'hFF, 2, 2,
                  128'hFFFFFFFFFFFFFFFFFF00000000000000, 128'hFF000000000000000000000000000000,
                  128'h00000000000000C8_0000000000000088};

      i_desc_valid    = 1'b0;
      i_desc_iv       = '0;
      i_desc_aad_bits = '0;
      i_desc_pt_bits  = '0;
      i_blk_valid     = 1'b0;
      i_blk_data      = '0;

      // Reset state
      #12;
      check("reset pipe_valid", 128'(o_pipe_valid), 128'd0);
      check("reset desc_ready", 128'(o_desc_ready), 128'd1);
      check("reset blk_ready", 128'(o_blk_ready), 128'd0);
      check("reset flags", 128'({o_new_instance, o_pt_instance, o_last, o_err}), 128'd0);
      check("reset instance_size", o_instance_size, 128'd0);
      check("reset iv", 128'(o_iv), 128'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int v = 0; v < 5; v++) run_vec(v);

      // Oversize descriptor: 2^39+1 bits is 2^32+1 blocks
      i_desc_valid    = 1'b1;
      i_desc_aad_bits = 64'd0;
      i_desc_pt_bits  = 64'h0000008000000001;
      @(posedge clk);
      #1;
      i_desc_valid = 1'b0;
      check("oversize err", 128'(o_err), 128'd1);
      check("oversize desc_ready", 128'(o_desc_ready), 128'd1);
      for (int c = 0; c < 3; c++) begin
         check($sformatf("oversize no beat c%0d", c), 128'(o_pipe_valid), 128'd0);
         @(posedge clk);
         #1;
      end
      run_vec(1);
      check("err sticky", 128'(o_err), 128'd1);

      // Reset after the second PT beat
      pt_beats        = 0;
      i_desc_valid    = 1'b1;
      i_desc_aad_bits = 64'd0;
      i_desc_pt_bits  = 64'd512;
      for (int c = 0; c < 20 && pt_beats < 2; c++) begin
         @(posedge clk);
         #1;
         i_desc_valid = 1'b0;
         if (o_pipe_valid) pt_beats++;
         i_blk_valid = 1'b1;
         i_blk_data  = blk(Base, c);
      end
      check("reset seq pt beats seen", 128'(pt_beats), 128'd2);
      i_blk_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("async rst pipe_valid", 128'(o_pipe_valid), 128'd0);
      check("async rst plain_text", o_plain_text, 128'd0);
      check("async rst instance_size", o_instance_size, 128'd0);
      check("async rst iv", 128'(o_iv), 128'd0);
      check("async rst flags", 128'({o_new_instance, o_pt_instance, o_last, o_err}), 128'd0);
      check("async rst desc_ready", 128'(o_desc_ready), 128'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post rst desc_ready", 128'(o_desc_ready), 128'd1);
      check("post rst pipe_valid", 128'(o_pipe_valid), 128'd0);
      run_vec(0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
